pipe_collide_score: RTL and testbench
=====================================

Name: pipe_collide_score

Overview:
Consumer side of the pipe position interface. It samples both pipe generators' (X, Y) outputs every clock together with the bird's vertical position. It detects bird/pipe and bird/floor/ceiling collisions, raises Lost, and counts pipes passed into a saturating score. It sits between the pipe generators and bird physics on one side, and the VGA/score display and game-control logic on the other.

Parameters:
BIRD_X, 10'd150, fixed left edge of bird sprite (pixels)
BIRD_W, 10'd20, bird width
BIRD_H, 10'd20, bird height
PIPE_W, 10'd60, pipe width; pipe X is the pipe's left edge
GAP_H, 10'd150, gap height; pipe Y is the top of the gap
FLOOR_Y, 10'd460, bird bottom at or below this row is a floor hit
PARK_X, 10'd640, pipe X >= PARK_X means off-screen; the pipe is ignored
SCORE_MAX, 10'd999, score saturation value

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
Start  in  1  game-run level, shared with the pipe generators
PipePosXA  in  10  pipe A left edge
PipePosYA  in  10  pipe A gap top
PipePosXB  in  10  pipe B left edge
PipePosYB  in  10  pipe B gap top
BirdPosY  in  10  bird top edge
Lost  out  1  high while in LOST
Playing  out  1  high while in PLAY
Score  out  10  pipes passed, binary, saturating
ScoreTick  out  1  one-cycle pulse on every score change

Behaviour:
- Clocking and reset:
  - Single clock domain (Clk).
  - Reset is synchronous and active-low: sampled on posedge Clk, Reset==0 resets.
  - Reset values: state=IDLE, Lost=0, Playing=0, Score=0, ScoreTick=0, passed flags=0, prev-X regs=10'd1023.
  - Reset overrides everything, including mid-game.
- All sums are done at 11 bits so that X+PIPE_W and Y+GAP_H cannot wrap.
- Per-pipe hit, combinational from current inputs:
  - Condition: X < PARK_X AND X < BIRD_X+BIRD_W AND X+PIPE_W > BIRD_X AND (BirdPosY < Y OR BirdPosY+BIRD_H > Y+GAP_H).
- Bound hit:
  - BirdPosY == 0, OR BirdPosY+BIRD_H >= FLOOR_Y.
- Per-pipe pass event:
  - Condition: X < PARK_X AND X+PIPE_W <= BIRD_X AND passed flag == 0.
  - On the event, the passed flag is set.
  - The flag clears when the pipe reloads, i.e. registered prev-X < current X. Prev-X is updated every cycle.
- State machine (IDLE, PLAY, LOST):
  - IDLE:
    - Playing=0, Lost=0.
    - If Start==1: go to PLAY; Score<=0; passed flags<=0.
  - PLAY:
    - Playing=1.
    - If Start==0: go to IDLE; Score is held.
    - Otherwise, if any hit (A, B or bound): go to LOST.
    - Otherwise, Score += number of pass events this cycle (0, 1 or 2), saturating at SCORE_MAX.
    - ScoreTick=1 for exactly one cycle when Score actually changed.
  - LOST:
    - Lost=1, Playing=0. Score is frozen.
    - Stays in LOST while Start==1.
    - If Start==0: go to IDLE. A new Start rising then clears Score.
- Latency: a hit condition present at posedge N sets Lost after edge N (visible in cycle N+1).
- Hit and pass in the same cycle: the hit wins and no score is added.
- Both pipes pass in the same cycle: +2, still saturating at SCORE_MAX.
- Parked pipes (X = 1023 while Start is low, or X >= PARK_X) never hit and never score.
- ScoreTick never asserts outside PLAY.

Optional Feature:
Macro: SCORE_BCD_EN
- Defined:
  - Adds output ScoreBcd [11:0]: three BCD digits, hundreds in [11:8].
  - Kept as its own BCD counter, updated on the same edge as Score, and equal to Score in decimal at all times.
  - Same clear, hold and saturate rules as Score (saturates at 12'h999).
- Not defined:
  - Port and logic are absent.
  - Display logic converts Score itself.

Decomposition:
- Shared package/header (flappy_defs):
  - State encodings: IDLE, PLAY, LOST as one-hot 3-bit localparams.
  - Screen constants: PARK_X, FLOOR_Y, the 10'd1023 park sentinel.
  - Bird and pipe geometry defaults.
- One sub-module, pipe_hit_check:
  - Instantiated twice, once per pipe.
  - Contains the hit compare, the pass compare, the prev-X register and the passed flag.
  - Outputs hit and pass_evt.
- The top holds the FSM, the score counter and the optional BCD counter.

Test Plan:
1. Reset=0 for 2 cycles, then Reset=1 with Start=0 -> IDLE; Lost=0, Playing=0, Score=0, ScoreTick=0.
2. Start=1, BirdPosY=200, pipe A at Y=150 stepping X from 200 down to 89 -> single pass event when X=90 (90+60=150), so Score=1 with one ScoreTick pulse; no further increment until X reloads (0 -> 1000) and the pipe passes again.
3. PLAY, pipe A at X=160, Y=150, BirdPosY=100 (above the gap) -> Lost=1 one cycle later; Score frozen; Start=0 -> IDLE; Start=1 -> Score=0.
4. BirdPosY=445 (445+20 >= 460) with no pipes on screen -> LOST. Separately, BirdPosY=0 -> LOST.
5. Pipes A and B both reach X=90 in the same cycle -> Score +2, a single ScoreTick. Preload Score=998 and repeat -> Score=999 (saturated).
6. Hit and pass in the same cycle (A passing while B overlaps) -> LOST, Score unchanged. Reset=0 mid-PLAY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pipe_collide_score_pkg.sv
// Shared constants for the pipe collision/score block: FSM encodings,
// screen limits, bird and pipe geometry.
package pipe_collide_score_pkg;

  localparam int unsigned POS_W = 10;
  localparam int unsigned SUM_W = 11;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_PLAY = 3'b010;
  localparam logic [2:0] ST_LOST = 3'b100;

  localparam logic [POS_W-1:0] BIRD_X        = 10'd150;
  localparam logic [POS_W-1:0] BIRD_W        = 10'd20;
  localparam logic [POS_W-1:0] BIRD_H        = 10'd20;
  localparam logic [POS_W-1:0] PIPE_W        = 10'd60;
  localparam logic [POS_W-1:0] GAP_H         = 10'd150;
  localparam logic [POS_W-1:0] FLOOR_Y       = 10'd460;
  localparam logic [POS_W-1:0] PARK_X        = 10'd640;
  localparam logic [POS_W-1:0] PARK_SENTINEL = 10'd1023;
  localparam logic [POS_W-1:0] SCORE_MAX     = 10'd999;
  localparam logic [11:0]      BCD_MAX       = 12'h999;

  // Zero-extend a position so geometry sums cannot wrap.
  function automatic logic [SUM_W-1:0] ext(input logic [POS_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pipe_collide_score_hit_check.sv
// Per-pipe collision and pass detection, with prev-X tracking so a pass
// is counted once per pipe lap.
module pipe_collide_score_hit_check
  import pipe_collide_score_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  input  logic [POS_W-1:0] bird_y_i,
  output logic             hit_c,
  output logic             pass_evt_c
);

  logic [POS_W-1:0] prev_x_q;
  logic             passed_q;
  logic             passed_d;
  logic             on_screen;
  logic             reload;

  always_comb begin
    on_screen  = (x_i < PARK_X);
    reload     = (prev_x_q < x_i);
    hit_c      = on_screen
                 && (ext(x_i) < ext(BIRD_X) + ext(BIRD_W))
                 && (ext(x_i) + ext(PIPE_W) > ext(BIRD_X))
                 && ((bird_y_i < y_i)
                     || (ext(bird_y_i) + ext(BIRD_H) > ext(y_i) + ext(GAP_H)));
    pass_evt_c = on_screen && (ext(x_i) + ext(PIPE_W) <= ext(BIRD_X)) && !passed_q;
    passed_d   = passed_q;
    // A fresh pass keeps the flag even if X moved up the same cycle.
    if (clr_i)           passed_d = 1'b0;
    else if (pass_evt_c) passed_d = 1'b1;
    else if (reload)     passed_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_x_q <= PARK_SENTINEL;
      passed_q <= 1'b0;
    end else begin
      prev_x_q <= x_i;
      passed_q <= passed_d;
    end
  end

endmodule

// File: rtl/pipe_collide_score.sv
// Game FSM (IDLE/PLAY/LOST) with collision detection and saturating score.
// Optional SCORE_BCD_EN adds a parallel three-digit BCD score output.
module pipe_collide_score
  import pipe_collide_score_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [POS_W-1:0] PipePosXA,
  input  logic [POS_W-1:0] PipePosYA,
  input  logic [POS_W-1:0] PipePosXB,
  input  logic [POS_W-1:0] PipePosYB,
  input  logic [POS_W-1:0] BirdPosY,
`ifdef SCORE_BCD_EN
  output logic [11:0]      ScoreBcd,
`endif
  output logic             Lost,
  output logic             Playing,
  output logic [POS_W-1:0] Score,
  output logic             ScoreTick
);

  logic [2:0]       state_q, state_d;
  logic [POS_W-1:0] score_q, score_d;
  logic             tick_q, tick_d;
  logic             clr_flags;
  logic             hit_a, hit_b, pass_a, pass_b;
  logic             bound_hit;
  logic [1:0]       n_pass;
  logic [SUM_W-1:0] score_sum;

  pipe_collide_score_hit_check u_pipe_a (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .clr_i      (clr_flags),
    .x_i        (PipePosXA),
    .y_i        (PipePosYA),
    .bird_y_i   (BirdPosY),
    .hit_c      (hit_a),
    .pass_evt_c (pass_a)
  );

  pipe_collide_score_hit_check u_pipe_b (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .clr_i      (clr_flags),
    .x_i        (PipePosXB),
    .y_i        (PipePosYB),
    .bird_y_i   (BirdPosY),
    .hit_c      (hit_b),
    .pass_evt_c (pass_b)
  );

`ifdef SCORE_BCD_EN
  logic [11:0] bcd_q, bcd_d;

  function automatic logic [11:0] bcd_inc1(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != BCD_MAX) begin
      if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) r[7:4] = v[7:4] + 4'd1;
        else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction
`endif

  always_comb begin
    bound_hit = (BirdPosY == '0) || (ext(BirdPosY) + ext(BIRD_H) >= ext(FLOOR_Y));
    n_pass    = {1'b0, pass_a} + {1'b0, pass_b};
    score_sum = ext(score_q) + SUM_W'(n_pass);
  end

  // Next-state and score update; a hit always beats a same-cycle pass.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    clr_flags = 1'b0;
`ifdef SCORE_BCD_EN
    bcd_d     = bcd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d   = ST_PLAY;
          score_d   = '0;
          clr_flags = 1'b1;
`ifdef SCORE_BCD_EN
          bcd_d     = '0;
`endif
        end
      end
      ST_PLAY: begin
        if (!Start) begin
          state_d = ST_IDLE;
        end else if (hit_a || hit_b || bound_hit) begin
          state_d = ST_LOST;
        end else begin
          score_d = (score_sum > ext(SCORE_MAX)) ? SCORE_MAX : score_sum[POS_W-1:0];
`ifdef SCORE_BCD_EN
          if (n_pass != 2'd0) bcd_d = bcd_inc1(bcd_q);
          if (n_pass == 2'd2) bcd_d = bcd_inc1(bcd_inc1(bcd_q));
`endif
        end
      end
      ST_LOST: begin
        if (!Start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tick_d = (state_q == ST_PLAY) && (score_d != score_q);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      tick_q  <= 1'b0;
`ifdef SCORE_BCD_EN
      bcd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      tick_q  <= tick_d;
`ifdef SCORE_BCD_EN
      bcd_q   <= bcd_d;
`endif
    end
  end

  assign Lost      = state_q[2];
  assign Playing   = state_q[1];
  assign Score     = score_q;
  assign ScoreTick = tick_q;
`ifdef SCORE_BCD_EN
  assign ScoreBcd  = bcd_q;
`endif

endmodule

// File: tb/tb_pipe_collide_score.sv
// Directed bench for pipe_collide_score: a vector table for reset/hit/bound
// cases plus hand sequences for passes, saturation and priority corners.
module tb_pipe_collide_score;

  localparam logic [9:0] P = 10'd1023;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [9:0] PipePosXA, PipePosYA, PipePosXB, PipePosYB, BirdPosY;
  logic       Lost, Playing, ScoreTick;
  logic [9:0] Score;
`ifdef SCORE_BCD_EN
  logic [11:0] ScoreBcd;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_collide_score dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .PipePosXA (PipePosXA),
    .PipePosYA (PipePosYA),
    .PipePosXB (PipePosXB),
    .PipePosYB (PipePosYB),
    .BirdPosY  (BirdPosY),
`ifdef SCORE_BCD_EN
    .ScoreBcd  (ScoreBcd),
`endif
    .Lost      (Lost),
    .Playing   (Playing),
    .Score     (Score),
    .ScoreTick (ScoreTick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [9:0] xa, ya, xb, yb, by;
    logic       lost, play;
    logic [9:0] score;
    logic       tick;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic rst, input logic start,
                              input logic [9:0] xa, input logic [9:0] ya,
                              input logic [9:0] xb, input logic [9:0] yb,
                              input logic [9:0] by, input logic lost,
                              input logic play, input logic [9:0] score,
                              input logic tick);
    vec_t v;
    v.rst = rst; v.start = start; v.xa = xa; v.ya = ya; v.xb = xb; v.yb = yb;
    v.by = by; v.lost = lost; v.play = play; v.score = score; v.tick = tick;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample just after the next rising edge.
  task automatic apply(input logic rst, input logic start,
                       input logic [9:0] xa, input logic [9:0] ya,
                       input logic [9:0] xb, input logic [9:0] yb,
                       input logic [9:0] by);
    Reset = rst; Start = start;
    PipePosXA = xa; PipePosYA = ya; PipePosXB = xb; PipePosYB = yb;
    BirdPosY = by;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic lost, input logic play,
                       input logic [9:0] score, input logic tick);
    n_tests++;
    if (Lost !== lost || Playing !== play || Score !== score || ScoreTick !== tick) begin
      n_fail++;
      $display("FAIL %s: got lost=%0b play=%0b score=%0d tick=%0b, want lost=%0b play=%0b score=%0d tick=%0b",
               name, Lost, Playing, Score, ScoreTick, lost, play, score, tick);
    end
  endtask

  initial begin
    int exp_score;
    int nxt;

    vecs[0]  = mk(0, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, P,   0,   P, 0,   200, 0, 1, 0, 0);
    vecs[4]  = mk(1, 1, 160, 150, P, 0,   100, 1, 0, 0, 0);
    vecs[5]  = mk(1, 1, 160, 150, P, 0,   100, 1, 0, 0, 0);
    vecs[6]  = mk(1, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, P,   0,   P, 0,   200, 0, 1, 0, 0);
    vecs[8]  = mk(1, 1, P,   0,   P, 0,   445, 1, 0, 0, 0);
    vecs[9]  = mk(1, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, P,   0,   P, 0,   200, 0, 1, 0, 0);
    vecs[11] = mk(1, 1, P,   0,   P, 0,   0,   1, 0, 0, 0);
    vecs[12] = mk(1, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[13] = mk(1, 1, P,   0,   P, 0,   440, 0, 1, 0, 0);
    vecs[14] = mk(1, 1, P,   0,   P, 0,   440, 1, 0, 0, 0);
    vecs[15] = mk(1, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[16] = mk(1, 1, P,   0,   P, 0,   439, 0, 1, 0, 0);
    vecs[17] = mk(1, 1, P,   0,   P, 0,   439, 0, 1, 0, 0);
    vecs[18] = mk(1, 1, 170, 150, P, 0,   100, 0, 1, 0, 0);
    vecs[19] = mk(1, 1, 169, 150, P, 0,   100, 1, 0, 0, 0);
    vecs[20] = mk(1, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);
    vecs[21] = mk(1, 1, P,   0,   P, 0,   200, 0, 1, 0, 0);
    vecs[22] = mk(1, 1, P,   0,   160, 150, 300, 1, 0, 0, 0);
    vecs[23] = mk(1, 0, P,   0,   P, 0,   200, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      apply(vecs[i].rst, vecs[i].start, vecs[i].xa, vecs[i].ya,
            vecs[i].xb, vecs[i].yb, vecs[i].by);
      check($sformatf("tbl[%0d]", i), vecs[i].lost, vecs[i].play,
            vecs[i].score, vecs[i].tick);
    end

    // Single pipe sweeping past the bird scores exactly once per lap.
    apply(1, 1, P, 0, P, 0, 200);
    check("sweep_start", 0, 1, 0, 0);
    for (int x = 200; x >= 89; x--) begin
      apply(1, 1, 10'(x), 150, P, 0, 200);
      check($sformatf("sweep_x%0d", x), 0, 1, (x <= 90) ? 10'd1 : 10'd0, (x == 90));
    end
    apply(1, 1, 0, 150, P, 0, 200);
    check("sweep_x0", 0, 1, 1, 0);
    apply(1, 1, 1000, 150, P, 0, 200);
    check("sweep_reload", 0, 1, 1, 0);
    apply(1, 1, 90, 150, P, 0, 200);
    check("sweep_pass2", 0, 1, 2, 1);
    apply(1, 1, P, 150, P, 0, 200);
    check("sweep_park", 0, 1, 2, 0);

    // Pipe hit freezes score; restart clears it.
    apply(1, 1, 160, 150, P, 0, 100);
    check("hit_lost", 1, 0, 2, 0);
    apply(1, 1, 160, 150, P, 0, 100);
    check("hit_hold", 1, 0, 2, 0);
    apply(1, 0, P, 0, P, 0, 200);
    check("hit_idle", 0, 0, 2, 0);
    apply(1, 1, P, 0, P, 0, 200);
    check("hit_restart", 0, 1, 0, 0);

    // Double pass, then climb to saturation two points at a time.
    apply(1, 1, 90, 150, 90, 150, 200);
    check("dbl_pass", 0, 1, 2, 1);
    apply(1, 1, 90, 150, 90, 150, 200);
    check("dbl_hold", 0, 1, 2, 0);
    exp_score = 2;
    for (int k = 0; k < 500; k++) begin
      apply(1, 1, 100, 150, 100, 150, 200);
      check($sformatf("sat_up%0d", k), 0, 1, 10'(exp_score), 0);
      nxt = (exp_score + 2 > 999) ? 999 : exp_score + 2;
      apply(1, 1, 90, 150, 90, 150, 200);
      check($sformatf("sat_pass%0d", k), 0, 1, 10'(nxt), (nxt != exp_score));
      exp_score = nxt;
    end
    check("sat_final", 0, 1, 999, 0);

    // Same-cycle hit on B and pass on A: hit wins.
    apply(1, 0, P, 0, P, 0, 200);
    check("prio_idle", 0, 0, 999, 0);
    apply(1, 1, P, 0, P, 0, 200);
    check("prio_start", 0, 1, 0, 0);
    apply(1, 1, 90, 150, P, 0, 200);
    check("prio_pass", 0, 1, 1, 1);
    apply(1, 1, P, 150, P, 0, 200);
    check("prio_reload", 0, 1, 1, 0);
    apply(1, 1, 90, 150, 160, 150, 100);
    check("prio_hit", 1, 0, 1, 0);

    // Reset in the middle of play.
    apply(1, 0, P, 0, P, 0, 200);
    check("mrst_idle", 0, 0, 1, 0);
    apply(1, 1, P, 0, P, 0, 200);
    check("mrst_start", 0, 1, 0, 0);
    apply(1, 1, 90, 150, P, 0, 200);
    check("mrst_pass", 0, 1, 1, 1);
    apply(0, 1, 90, 150, P, 0, 200);
    check("mrst_reset", 0, 0, 0, 0);
    apply(1, 0, P, 0, P, 0, 200);
    check("mrst_after", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
